// File: rtl/run_monitor.sv
// run_monitor: sequences the core reset, times the run, waits for the masked
// register probes to settle and then issues a pass/fail/timeout verdict.
module run_monitor #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned RESET_CYCLES   = 4,
  parameter int unsigned STABLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [NUM_CH*WIDTH-1:0] probe,
  input  logic [NUM_CH*WIDTH-1:0] expected,
  output logic                    core_reset_n,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [NUM_CH-1:0]       mismatch,
  output logic [CNT_W-1:0]        cycle_count
);

  localparam int unsigned BUS_W  = NUM_CH * WIDTH;
  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state, state_d;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic [STAB_W-1:0] stab_cnt, stab_cnt_d;
  logic [BUS_W-1:0]  prev, prev_d, masked;
  logic [NUM_CH-1:0] cmp, mismatch_d;
  logic [CNT_W-1:0]  cycle_count_d, cnt_inc;
  logic              pass_d, timeout_d, core_reset_n_d, busy_d, done_d;
  logic              settle, expire;

  // Mask-expanded probe view and per-channel golden compare
  always_comb begin
    masked = '0;
    cmp    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      masked[i*WIDTH +: WIDTH] = probe[i*WIDTH +: WIDTH] & {WIDTH{ch_mask[i]}};
      cmp[i] = ch_mask[i] & (probe[i*WIDTH +: WIDTH] != expected[i*WIDTH +: WIDTH]);
    end
  end

  // Next-state, counters and verdict
  always_comb begin
    state_d       = state;
    hold_cnt_d    = hold_cnt;
    stab_cnt_d    = stab_cnt;
    prev_d        = prev;
    mismatch_d    = mismatch;
    pass_d        = pass;
    timeout_d     = timeout;
    cycle_count_d = cycle_count;
    cnt_inc       = cycle_count + CNT_W'(1);
    settle        = 1'b0;
    expire        = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_HOLD;
          hold_cnt_d    = '0;
          stab_cnt_d    = '0;
          mismatch_d    = '0;
          pass_d        = 1'b0;
          timeout_d     = 1'b0;
          cycle_count_d = '0;
        end
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt + HOLD_W'(1);
        end
      end
      S_RUN: begin
        cycle_count_d = cnt_inc;
        prev_d        = masked;
        // cycle_count==0 marks the first RUN cycle: prev is not yet valid
        if ((cycle_count != '0) && (masked == prev)) begin
          stab_cnt_d = stab_cnt + STAB_W'(1);
        end else begin
          stab_cnt_d = '0;
        end
        settle = (stab_cnt_d == STAB_W'(STABLE_CYCLES));
        expire = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
        // Stability takes priority over a coincident timeout
        if (settle || expire) begin
          state_d    = S_DONE;
          mismatch_d = cmp;
          pass_d     = settle && (cmp == '0);
          timeout_d  = !settle;
        end
      end
      default: state_d = S_IDLE;
    endcase

    core_reset_n_d = (state_d == S_RUN) || (state_d == S_DONE);
    busy_d         = (state_d == S_HOLD) || (state_d == S_RUN);
    done_d         = (state_d == S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      hold_cnt     <= '0;
      stab_cnt     <= '0;
      prev         <= '0;
      mismatch     <= '0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      cycle_count  <= '0;
      core_reset_n <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      hold_cnt     <= hold_cnt_d;
      stab_cnt     <= stab_cnt_d;
      prev         <= prev_d;
      mismatch     <= mismatch_d;
      pass         <= pass_d;
      timeout      <= timeout_d;
      cycle_count  <= cycle_count_d;
      core_reset_n <= core_reset_n_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
- Synthesizable run controller and self-checker for the pipelined RISC-V core. It replaces the fixed free-running bench with a sequenced reset, multi-register watch and pass/fail verdict.
- Sequences the core's reset, counts run cycles and watches NUM_CH probe buses (architectural register taps such as x14).
- Declares completion once the masked probes have been stable for STABLE_CYCLES. It then compares them against expected values and flags pass, fail or timeout.
- Sits between the bench top and the processor instance. It is reusable for FPGA bring-up.

Parameters:
NUM_CH, 4, number of watched probe channels (>=1)
WIDTH, 32, bits per probe channel
RESET_CYCLES, 4, cycles core_reset_n is held low after start (>=1)
STABLE_CYCLES, 8, consecutive unchanged-compare cycles that define "settled" (>=1)
TIMEOUT_CYCLES, 1000, maximum RUN cycles before timeout; must be < 2^CNT_W
CNT_W, 16, width of cycle_count

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 forces IDLE immediately
start  in  1  pulse; begins a run from IDLE or DONE
ch_mask  in  NUM_CH  1 = channel participates in stability and compare
probe  in  NUM_CH*WIDTH  live register taps; channel i at [i*WIDTH +: WIDTH]
expected  in  NUM_CH*WIDTH  golden values, same packing
core_reset_n  out  1  active-low reset to the processor
busy  out  1  high in HOLD and RUN
done  out  1  verdict valid
pass  out  1  all masked channels matched, no timeout
timeout  out  1  run ended by TIMEOUT_CYCLES
mismatch  out  NUM_CH  latched per-channel (mask & probe!=expected)
cycle_count  out  CNT_W  RUN cycles elapsed this run

Behaviour:
- Reset state (asynchronous):
  - state=IDLE.
  - All outputs 0, including core_reset_n=0; internal counters 0.
- IDLE:
  - core_reset_n=0.
  - start=1 -> HOLD next cycle.
- HOLD:
  - core_reset_n=0; busy=1.
  - On entry, clear done, pass, timeout, mismatch, cycle_count, hold_cnt and stab_cnt.
  - Stay exactly RESET_CYCLES cycles, then -> RUN.
  - core_reset_n goes 1 on the first RUN cycle.
- RUN:
  - core_reset_n=1; busy=1; cycle_count increments every RUN cycle (first RUN cycle shows 1 at its end).
  - prev register captures (probe & mask-expanded) every cycle.
  - First RUN cycle: capture only, stab_cnt stays 0.
  - Later cycles: masked probe == prev -> stab_cnt+1, else stab_cnt=0.
  - stab_cnt reaches STABLE_CYCLES -> DONE next cycle:
    - mismatch <= mask & (probe!=expected), sampled that cycle;
    - pass <= (mismatch==0); timeout <= 0.
  - Otherwise, cycle_count reaches TIMEOUT_CYCLES -> DONE next cycle:
    - timeout <= 1; pass <= 0; mismatch latched the same way.
  - Stable and timeout in the same cycle: stability wins, so timeout=0 and pass is per compare.
- DONE:
  - done=1, busy=0; verdict and cycle_count held.
  - core_reset_n stays 1 so the core stays observable.
  - start -> HOLD, which clears the verdict.
- start while busy: ignored.
- ch_mask=0: all channels trivially stable and matching, so pass=1 after 1+STABLE_CYCLES RUN cycles.
- ch_mask sampled live. Changing it mid-RUN may reset stab_cnt; the bench must not do this.
- reset low mid-run: immediate IDLE, core_reset_n=0 combinationally via the flop async clear, verdict lost.
- Minimum latency: start to done = 1 + RESET_CYCLES + (1+STABLE_CYCLES) + 1 cycles.

Test Plan:
Parameters for all scenarios: NUM_CH=2, WIDTH=32, RESET_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=100.

- Reset then start, with probes constant at expected (ch0=0x0000000A, ch1=0x5, mask=2'b11):
  - core_reset_n low for 4 cycles after the start cycle;
  - done rises 10 cycles after HOLD exit;
  - pass=1, timeout=0, mismatch=0, cycle_count=9.
- Probe ch1 settles at 0x6 while expected is 0x5:
  - pass=0, mismatch=2'b10, timeout=0.
- Same mismatch with mask=2'b01:
  - pass=1, mismatch=0.
- Probe ch0 toggles every 3 cycles forever:
  - done at cycle_count=100, timeout=1, pass=0.
- Probe ch0 last changes at RUN cycle 92, so stable and timeout coincide at 100:
  - timeout=0, pass per compare.
- reset pulsed low mid-RUN:
  - core_reset_n=0 and busy=0 in the same cycle;
  - a subsequent start completes a fresh run correctly;
  - start pulsed during RUN has no effect.
